// File: rtl/apb_master_ctrl_pkg.sv
// Shared types for the APB master controller: transfer size, FSM state, direction.
package apb_master_ctrl_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } cs_size;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } ctrl_state_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

endpackage

// File: rtl/apb_if.sv
// APB4 bus bundle shared by master and slave.
interface apb_if #(
  parameter int DAT_W  = 32,
  parameter int ADDR_W = 32
);
  logic               sel;
  logic               enable;
  logic               write;
  logic [ADDR_W-1:0]  addr;
  logic [DAT_W-1:0]   wdata;
  logic [DAT_W/8-1:0] strb;
  logic [2:0]         prot;
  logic               ready;
  logic [DAT_W-1:0]   rdata;
  logic               slverr;

  modport master (
    output sel, enable, write, addr, wdata, strb, prot,
    input  ready, rdata, slverr
  );

  modport slave (
    input  sel, enable, write, addr, wdata, strb, prot,
    output ready, rdata, slverr
  );
endinterface

// File: rtl/apb_master_ctrl_lane.sv
// Byte-lane steering: strobes, write-data shift, read-data extract/extend, alignment check.
module apb_lane_align
  import apb_master_ctrl_pkg::*;
#(
  parameter int DAT_W = 32
) (
  input  cs_size             size,
  input  logic [2:0]         offset,
  input  logic               is_unsigned,
  input  logic [DAT_W-1:0]   wdata,
  input  logic [DAT_W-1:0]   rdata,
  output logic [DAT_W/8-1:0] strb,
  output logic [DAT_W-1:0]   wdata_sh,
  output logic [DAT_W-1:0]   rdata_ext,
  output logic               misaligned
);
  localparam int STRB_W = DAT_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [OFF_W-1:0] off;
  logic [OFF_W+2:0] bit_sh;
  logic [7:0]       base;
  logic [DAT_W-1:0] keep;
  logic [DAT_W-1:0] rdata_sh;
  logic             sign;

  assign off    = offset[OFF_W-1:0];
  assign bit_sh = {off, 3'b000};

  // Per-size lane mask, sign bit position and alignment rule.
  always_comb begin
    base       = 8'h00;
    keep       = '1;
    sign       = 1'b0;
    misaligned = 1'b0;
    rdata_sh   = rdata >> bit_sh;
    case (size)
      SIZE_B: begin
        base = 8'h01;
        keep = DAT_W'(8'hFF);
        sign = rdata_sh[7];
      end
      SIZE_H: begin
        base       = 8'h03;
        keep       = DAT_W'(16'hFFFF);
        sign       = rdata_sh[15];
        misaligned = offset[0];
      end
      SIZE_W: begin
        base       = 8'h0F;
        keep       = DAT_W'(32'hFFFF_FFFF);
        sign       = rdata_sh[31];
        misaligned = (offset[1:0] != 2'b00);
      end
      SIZE_D: begin
        base       = 8'hFF;
        keep       = '1;
        sign       = rdata_sh[DAT_W-1];
        misaligned = (DAT_W == 32) || (offset != 3'b000);
      end
      default: ;
    endcase
    strb      = STRB_W'(base) << off;
    wdata_sh  = wdata << bit_sh;
    rdata_ext = (rdata_sh & keep) | ((!is_unsigned && sign) ? ~keep : '0);
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master: one request in, one response out, registered bus signals, watchdog.
//
// Handshakes: a request transfers on a clock edge where req_valid_i && req_ready_o;
// a response transfers on an edge where rsp_valid_o && rsp_ready_i. While valid is
// high and ready is low, the valid side holds its payload stable.
module apb_master_ctrl
  import apb_master_ctrl_pkg::*;
#(
  parameter int DAT_W       = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  cs_size            req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DAT_W-1:0]  req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DAT_W-1:0]  rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  output ctrl_state_e       dbg_state_o,
  apb_if.master             apb
);
  localparam int STRB_W = DAT_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 2);

  ctrl_state_e        state, state_next;
  logic               sel_next, en_next;
  logic               sel_q, en_q, write_q, uns_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DAT_W-1:0]   wdata_q, rdata_q;
  logic [STRB_W-1:0]  strb_q;
  cs_size             size_q;
  logic [2:0]         off_q;
  logic               err_q, to_q;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic               accept, timeout_hit;

  cs_size             la_size;
  logic [2:0]         la_off;
  logic               la_uns, la_mis;
  logic [STRB_W-1:0]  la_strb;
  logic [DAT_W-1:0]   la_wdata, la_rdata;

  assign accept      = req_valid_i && req_ready_o;
  assign cnt_inc     = cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // In IDLE the lane logic looks at the incoming request; afterwards at the held one.
  assign la_size = (state == ST_IDLE) ? req_size_i : size_q;
  assign la_off  = (state == ST_IDLE) ? req_addr_i[2:0] : off_q;
  assign la_uns  = (state == ST_IDLE) ? req_unsigned_i : uns_q;

  apb_lane_align #(.DAT_W(DAT_W)) u_lane (
    .size        (la_size),
    .offset      (la_off),
    .is_unsigned (la_uns),
    .wdata       (req_wdata_i),
    .rdata       (apb.rdata),
    .strb        (la_strb),
    .wdata_sh    (la_wdata),
    .rdata_ext   (la_rdata),
    .misaligned  (la_mis)
  );

  // Next-state logic and next values of the registered psel/penable.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (accept) state_next = la_mis ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (apb.ready || timeout_hit) state_next = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    sel_next = (state_next == ST_SETUP) || (state_next == ST_ACCESS);
    en_next  = (state_next == ST_ACCESS);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Request capture, bus control, watchdog counter and response capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
      write_q <= READ;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      size_q  <= SIZE_B;
      off_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt     <= '0;
    end else begin
      sel_q <= sel_next;
      en_q  <= en_next;
      cnt   <= ((state == ST_ACCESS) && (state_next == ST_ACCESS)) ? cnt_inc : '0;
      if (state == ST_IDLE && accept) begin
        write_q <= req_write_i;
        uns_q   <= req_unsigned_i;
        size_q  <= req_size_i;
        off_q   <= req_addr_i[2:0];
        addr_q  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wdata_q <= req_write_i ? la_wdata : '0;
        strb_q  <= req_write_i ? la_strb : '0;
        rdata_q <= '0;
        err_q   <= la_mis;
        to_q    <= 1'b0;
      end else if (state == ST_ACCESS) begin
        if (apb.ready) begin
          err_q   <= apb.slverr;
          to_q    <= 1'b0;
          rdata_q <= (apb.slverr || write_q) ? '0 : la_rdata;
        end else if (timeout_hit) begin
          err_q   <= 1'b1;
          to_q    <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign apb.sel       = sel_q;
  assign apb.enable    = en_q;
  assign apb.write     = write_q;
  assign apb.addr      = addr_q;
  assign apb.wdata     = wdata_q;
  assign apb.strb      = strb_q;
  assign apb.prot      = 3'b000;

  assign req_ready_o   = (state == ST_IDLE);
  assign rsp_valid_o   = (state == ST_RESP);
  assign busy_o        = (state != ST_IDLE);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = to_q;
  assign dbg_state_o   = state;

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
Parametrised APB4 master controller and successor of the single-beat APB controller. Accepts one request at a time over a valid/ready request channel and returns one response over a valid/ready response channel. Registers every APB request signal and derives byte strobes and lane-shifted write data from the transfer size and the address offset. Detects misaligned requests without starting a bus transfer, and aborts hung transfers with a watchdog. Sits between the core/debug load-store path and the APB fabric.

Parameters:
DAT_W, 32, APB data width; legal values are 32 and 64.
ADDR_W, 32, APB address width.
TIMEOUT_CYC, 256, number of ACCESS cycles without pready before the transfer is aborted; 0 disables the watchdog.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when high together with req_valid_i
req_write_i  input  1  1 = write, 0 = read
req_size_i  input  cs_size  transfer size: SIZE_B, SIZE_H, SIZE_W or SIZE_D
req_unsigned_i  input  1  read result is zero-extended when 1 and sign-extended when 0
req_addr_i  input  ADDR_W  byte address
req_wdata_i  input  DAT_W  write data, right-aligned
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed
rsp_rdata_o  output  DAT_W  read data, right-aligned and extended
rsp_err_o  output  1  slverr, misalignment or timeout
rsp_timeout_o  output  1  error was caused by the watchdog
busy_o  output  1  high in every state except IDLE
apb  apb_if.master  -  APB4 bus, instantiated with matching DAT_W and ADDR_W

Behaviour:
- Reset: state is IDLE; apb.sel, apb.enable, apb.write = 0; apb.addr, apb.wdata, apb.strb = 0; rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; rsp_rdata_o = 0; the watchdog counter = 0.
- A reset asserted mid-transfer drops apb.sel and apb.enable asynchronously and discards the transfer; no response is produced for it.
- States are IDLE, SETUP, ACCESS and RESP.
- req_ready_o = (state == IDLE).
- IDLE: on req_valid_i && req_ready_o, register the address, data, strobes, direction, size and unsigned flag.
  - Misaligned request: go to RESP with err=1.
  - Otherwise: go to SETUP.
- Alignment rule: the request is misaligned if any of these hold:
  - SIZE_H and addr[0] != 0;
  - SIZE_W and addr[1:0] != 0;
  - SIZE_D and addr[2:0] != 0;
  - SIZE_D and DAT_W == 32.
- SETUP: apb.sel = 1, apb.enable = 0. Always lasts one cycle, then go to ACCESS.
- ACCESS: apb.sel = 1, apb.enable = 1.
  - On apb.ready: capture apb.slverr and rdata, then go to RESP.
  - Otherwise the counter increments. When the counter equals TIMEOUT_CYC and TIMEOUT_CYC != 0: go to RESP with err=1 and timeout=1.
  - The counter clears on leaving ACCESS.
- RESP: rsp_valid_o = 1; apb.sel and apb.enable = 0. The response is held stable until rsp_ready_i is high, then go to IDLE.
- Latency from acceptance (edge 0) with zero wait states:
  - SETUP in cycle 1, ACCESS in cycle 2, rsp_valid_o in cycle 3.
  - Each wait state adds 1 cycle.
  - A misaligned request gives rsp_valid_o in cycle 1.
- All APB request signals are registered; they do not change between SETUP and the end of ACCESS.
- Bus address: apb.addr = req_addr with the low log2(DAT_W/8) bits cleared.
- Strobes, with off = the low log2(DAT_W/8) address bits:
  - Writes: base mask shifted left by off. Base masks: B = 1, H = 0x3, W = 0xF, D = 0xFF.
  - Reads: apb.strb = 0.
- Write data = req_wdata_i shifted left by 8*off; apb.wdata = 0 on reads.
- Read data = apb.rdata shifted right by 8*off, then truncated to the size and extended per req_unsigned_i.
  - A write response returns rsp_rdata_o = 0.
  - Any error response returns rsp_rdata_o = 0.
- apb.slverr sampled with apb.ready gives rsp_err_o = 1 and rsp_timeout_o = 0.

Decomposition:
- Package typedefs:
  - extend cs_size with SIZE_D;
  - add the state enum for this block;
  - add READ/WRITE constants.
- Sub-module apb_lane_align (purely combinational):
  - inputs size, offset, wdata and rdata;
  - outputs strb, shifted wdata, extracted and extended rdata, and misaligned.
- The FSM, registers and watchdog stay in apb_master_ctrl.

Test Plan:
- Reset then idle: all outputs at their reset values; req_ready_o = 1; apb.sel = 0.
- Word write, 0x1000, wdata 0xDEADBEEF, slave inserts 2 wait states: exactly one SETUP cycle; strb = 0xF; addr = 0x1000; rsp_valid_o 5 cycles after acceptance with err = 0.
- Byte read, 0x1003, slave rdata 0x80123456, req_unsigned_i = 0: strb = 0; rsp_rdata_o = 0xFFFFFF80. Repeat with req_unsigned_i = 1: rsp_rdata_o = 0x00000080.
- Halfword write to 0x1001: apb.sel never asserts; rsp_valid_o in cycle 1 with err = 1 and timeout = 0. Halfword write to 0x1002: strb = 0xC and wdata shifted by 16.
- TIMEOUT_CYC = 8, slave never ready: psel stays high for 1 SETUP cycle plus 8 ACCESS cycles, then drops; response has err = 1 and timeout = 1; the next request proceeds normally.
- Response back-pressure (rsp_ready_i low for 5 cycles): response fields stay stable and req_ready_o = 0. Separately, rst pulsed during ACCESS: sel and enable drop immediately and no rsp_valid_o follows.
